vga_logo_scan: RTL

Raster scan generator and pixel compositor for the VGA logo display: it drives the pixel coordinates (x, y) and the horizontal scroll offset (delt) consumed by the logo hit-test painters, and turns their combined hit flag into RGB and sync outputs. It sits between the board clock and the VGA connector, with the combinational letter painters hanging off its x/y/delt/hit interface. The block also animates the logo by bouncing delt back and forth once per frame.

---
 rtl/vga_logo_scan.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vga_logo_scan.sv
// Raster scan generator and pixel compositor for the VGA logo display.
// Drives x/y/delt to the logo painters and registers their hit flag into RGB plus syncs.
module vga_logo_scan #(
  parameter int          H_VIS     = 800,
  parameter int          H_FP      = 56,
  parameter int          H_SYNC    = 120,
  parameter int          H_BP      = 64,
  parameter int          V_VIS     = 600,
  parameter int          V_FP      = 37,
  parameter int          V_SYNC    = 6,
  parameter int          V_BP      = 23,
  parameter int          DELT_MAX  = 200,
  parameter int          DELT_STEP = 2,
  parameter logic [8:0]  FG        = 9'b111_111_000,
  parameter logic [8:0]  BG        = 9'b000_000_011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enble,
  input  logic        hit,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [10:0] delt,
  output logic        hs,
  output logic        vs,
  output logic [2:0]  r,
  output logic [2:0]  g,
  output logic [2:0]  b
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] X_VIS    = 11'(H_VIS);
  localparam logic [10:0] Y_VIS    = 11'(V_VIS);
  localparam logic [10:0] Y_UPDATE = 11'(V_VIS - 1);
  localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);
  localparam logic [11:0] MAX_W    = 12'(DELT_MAX);
  localparam logic [11:0] STEP_W   = 12'(DELT_STEP);
  localparam logic [10:0] MAX_N    = 11'(DELT_MAX);
  localparam logic [10:0] STEP_N   = 11'(DELT_STEP);

  typedef enum logic {RIGHT, LEFT} dir_t;

  dir_t        dir;
  dir_t        dir_next;
  logic [10:0] delt_next;

  logic line_end;
  logic frame_update;
  logic visible;
  logic hs_raw;
  logic vs_raw;

  assign line_end = (x == X_LAST);
  // Last clock of the final visible line: delt moves only while the screen is blanked.
  assign frame_update = line_end && (y == Y_UPDATE) && enble;
  assign visible = (x < X_VIS) && (y < Y_VIS);
  assign hs_raw = (x >= HS_START) && (x < HS_END);
  assign vs_raw = (y >= VS_START) && (y < VS_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (line_end) begin
      x <= '0;
      y <= (y == Y_LAST) ? 11'd0 : y + 11'd1;
    end else begin
      x <= x + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs <= 1'b0;
      vs <= 1'b0;
      {r, g, b} <= '0;
    end else begin
      hs <= hs_raw;
      vs <= vs_raw;
      {r, g, b} <= visible ? (hit ? FG : BG) : 9'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir  <= RIGHT;
      delt <= '0;
    end else begin
      dir  <= dir_next;
      delt <= delt_next;
    end
  end

  // Saturating bounce: the widened sum keeps the upper test free of overflow.
  always_comb begin
    dir_next  = dir;
    delt_next = delt;
    if (frame_update) begin
      case (dir)
        RIGHT: begin
          if (({1'b0, delt} + STEP_W) >= MAX_W) begin
            delt_next = MAX_N;
            dir_next  = LEFT;
          end else begin
            delt_next = delt + STEP_N;
          end
        end
        LEFT: begin
          if (delt <= STEP_N) begin
            delt_next = '0;
            dir_next  = RIGHT;
          end else begin
            delt_next = delt - STEP_N;
          end
        end
        default: begin
          delt_next = '0;
          dir_next  = RIGHT;
        end
      endcase
    end
  end

endmodule
